// File: rtl/tiny_dnn_pkg.sv
// Shared widths, word types and the accumulator-to-output conversion used by out_buf.
package tiny_dnn_pkg;

    localparam int ACC_W = 32;
    localparam int OUT_W = 16;
    localparam int AW    = 12;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] out_t;

    // Round half up, arithmetic shift by frac, then clamp to the signed OUT_W range.
    function automatic out_t sat_round(input acc_t word, input int unsigned frac);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] half;
        logic signed [ACC_W:0] shifted;
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        out_t                  res;
        ext     = {word[ACC_W-1], word};
        half    = {{ACC_W{1'b0}}, 1'b1} << (frac - 32'd1);
        shifted = (ext + half) >>> frac;
        hi      = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
        lo      = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
        if (shifted > hi) begin
            res = hi[OUT_W-1:0];
        end else if (shifted < lo) begin
            res = lo[OUT_W-1:0];
        end else begin
            res = shifted[OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/out_buf_ram.sv
// One accumulation bank: synchronous, read-first RAM with one write port,
// a free-running read port for read-modify-write and an enabled stream read port.
module out_buf_ram #(
    parameter int W     = 32,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] rmw_addr,
    output logic [W-1:0]  rmw_q,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_q
);

    logic [W-1:0] mem [DEPTH];

    // Read-first array: reads return the word as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rmw_q <= mem[rmw_addr];
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/out_buf.sv
// Double-banked output accumulation buffer: 3-stage write/accumulate pipeline into one bank,
// rounded and saturated streaming of the other. Optional ReLU on readout with `OUT_BUF_RELU_EN.
module out_buf
    import tiny_dnn_pkg::*;
#(
    parameter int FRAC  = 8,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_acc,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_bank,
    input  acc_t          wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_bank,
`ifdef OUT_BUF_RELU_EN
    input  logic          relu_en,
`endif
    output out_t          dst_data,
    output logic          err_addr
);

    // One extra bit so DEPTH == 2**AW never flags an address as out of range.
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    logic          wr_oor_s, rd_oor_s;
    logic          s1_valid_r, s1_acc_r, s1_bank_r;
    logic [AW-1:0] s1_addr_r;
    acc_t          s1_data_r;
    logic          s2_valid_r, s2_bank_r;
    logic [AW-1:0] s2_addr_r;
    acc_t          s2_sum_r;
    logic          s3_valid_r, s3_bank_r;
    logic [AW-1:0] s3_addr_r;
    acc_t          s3_sum_r;
    logic [ACC_W-1:0] rmw_q0_s, rmw_q1_s, rd_q0_s, rd_q1_s;
    acc_t          old_s, sum_s;
    logic          we0_s, we1_s;
    logic          rd_seen_r, rd_oor_r, rd_bank_r;
    out_t          conv_s, dst_s;

    assign wr_oor_s = ({1'b0, wr_addr} >= DEPTH_X);
    assign rd_oor_s = ({1'b0, rd_addr} >= DEPTH_X);

    // Select the old word: S2 (writing now) and S3 (written last edge) are newer than the RAM read.
    always_comb begin
        old_s = s1_bank_r ? acc_t'(rmw_q1_s) : acc_t'(rmw_q0_s);
        if (s2_valid_r && s2_addr_r == s1_addr_r && s2_bank_r == s1_bank_r) begin
            old_s = s2_sum_r;
        end else if (s3_valid_r && s3_addr_r == s1_addr_r && s3_bank_r == s1_bank_r) begin
            old_s = s3_sum_r;
        end else begin
            old_s = s1_bank_r ? acc_t'(rmw_q1_s) : acc_t'(rmw_q0_s);
        end
        sum_s = s1_acc_r ? (old_s + s1_data_r) : s1_data_r;
    end

    // Write pipeline; out-of-range requests never become valid.
    always_ff @(posedge clk) begin
        s1_acc_r  <= wr_acc;
        s1_addr_r <= wr_addr;
        s1_bank_r <= wr_bank;
        s1_data_r <= wr_data;
        s2_addr_r <= s1_addr_r;
        s2_bank_r <= s1_bank_r;
        s2_sum_r  <= sum_s;
        s3_addr_r <= s2_addr_r;
        s3_bank_r <= s2_bank_r;
        s3_sum_r  <= s2_sum_r;
        if (rst) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            s3_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= wr_en && !wr_oor_s;
            s2_valid_r <= s1_valid_r;
            s3_valid_r <= s2_valid_r;
        end
    end

    assign we0_s = s2_valid_r && !s2_bank_r;
    assign we1_s = s2_valid_r && s2_bank_r;

    out_buf_ram #(.W(ACC_W), .AW(AW), .DEPTH(DEPTH)) u_bank0 (
        .clk      (clk),
        .we       (we0_s),
        .waddr    (s2_addr_r),
        .wdata    (s2_sum_r),
        .rmw_addr (wr_addr),
        .rmw_q    (rmw_q0_s),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_q     (rd_q0_s)
    );

    out_buf_ram #(.W(ACC_W), .AW(AW), .DEPTH(DEPTH)) u_bank1 (
        .clk      (clk),
        .we       (we1_s),
        .waddr    (s2_addr_r),
        .wdata    (s2_sum_r),
        .rmw_addr (wr_addr),
        .rmw_q    (rmw_q1_s),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_q     (rd_q1_s)
    );

    // Read-side state, captured only on rd_en so dst_data holds through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_seen_r <= 1'b0;
            rd_oor_r  <= 1'b0;
            rd_bank_r <= 1'b0;
        end else if (rd_en) begin
            rd_seen_r <= 1'b1;
            rd_oor_r  <= rd_oor_s;
            rd_bank_r <= rd_bank;
        end else begin
            rd_seen_r <= rd_seen_r;
            rd_oor_r  <= rd_oor_r;
            rd_bank_r <= rd_bank_r;
        end
    end

    // Sticky address error, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr <= 1'b0;
        end else if ((wr_en && wr_oor_s) || (rd_en && rd_oor_s)) begin
            err_addr <= 1'b1;
        end else begin
            err_addr <= err_addr;
        end
    end

    // Conversion of the held RAM word; all inputs are registers.
    always_comb begin
        conv_s = sat_round(rd_bank_r ? acc_t'(rd_q1_s) : acc_t'(rd_q0_s), FRAC);
        dst_s  = {OUT_W{1'b0}};
        if (!rd_seen_r || rd_oor_r) begin
            dst_s = {OUT_W{1'b0}};
`ifdef OUT_BUF_RELU_EN
        end else if (relu_en && conv_s[OUT_W-1]) begin
            dst_s = {OUT_W{1'b0}};
`endif
        end else begin
            dst_s = conv_s;
        end
    end

    assign dst_data = dst_s;

endmodule

// File: tb/tb_out_buf.sv
// Directed self-checking bench for out_buf (DEPTH=3000 so out-of-range addresses exist).
module tb_out_buf;
    import tiny_dnn_pkg::*;

    logic          clk = 1'b0;
    logic          rst, wr_en, wr_acc, wr_bank, rd_en, rd_bank, err_addr;
    logic [AW-1:0] wr_addr, rd_addr;
    acc_t          wr_data;
    out_t          dst_data;
    out_t          v;
    int            checks = 0;
    int            errors = 0;
`ifdef OUT_BUF_RELU_EN
    logic          relu_en = 1'b0;
`endif

    always #5 clk = ~clk;

    out_buf #(.FRAC(8), .DEPTH(3000)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_acc   (wr_acc),
        .wr_addr  (wr_addr),
        .wr_bank  (wr_bank),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_bank  (rd_bank),
`ifdef OUT_BUF_RELU_EN
        .relu_en  (relu_en),
`endif
        .dst_data (dst_data),
        .err_addr (err_addr)
    );

    // batch_ctrl never reads and writes the same bank in one cycle.
    always @(posedge clk) begin
        if (!rst && wr_en && rd_en && wr_bank == rd_bank) begin
            $display("FAIL same_bank_access wr_bank=%0d rd_bank=%0d required different", wr_bank, rd_bank);
            errors++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic bank, input int addr, input int data, input logic acc);
        wr_en = 1'b1; wr_bank = bank; wr_addr = AW'(addr); wr_data = acc_t'(data); wr_acc = acc;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic bank, input int addr, output out_t val);
        rd_en = 1'b1; rd_bank = bank; rd_addr = AW'(addr);
        tick();
        rd_en = 1'b0;
        val = dst_data;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_acc = 1'b0; wr_bank = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_bank = 1'b0; rd_addr = '0;
        idle(3);
        rst = 1'b0;
        tick();
        checks++; if (dst_data !== 16'sd0) begin errors++; $display("FAIL reset_dst got %0d exp 0", dst_data); end
        checks++; if (err_addr !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err_addr); end
    endtask

    task automatic test_write_read();
        wr(1'b0, 5, 1280, 1'b0); idle(2); rd(1'b0, 5, v);
        checks++; if (v !== 16'sd5) begin errors++; $display("FAIL wr_1280 got %0d exp 5", v); end
        wr(1'b0, 5, 1408, 1'b0); idle(2); rd(1'b0, 5, v);
        checks++; if (v !== 16'sd6) begin errors++; $display("FAIL wr_1408 got %0d exp 6", v); end
    endtask

    task automatic test_forwarding();
        wr(1'b1, 7, 1000, 1'b0); wr(1'b1, 7, 24, 1'b1); wr(1'b1, 7, 256, 1'b1); idle(2); rd(1'b1, 7, v);
        checks++; if (v !== 16'sd5) begin errors++; $display("FAIL fwd_b2b got %0d exp 5", v); end
        wr(1'b1, 9, 1000, 1'b0); idle(1); wr(1'b1, 9, 280, 1'b1); idle(2); rd(1'b1, 9, v);
        checks++; if (v !== 16'sd5) begin errors++; $display("FAIL fwd_gap1 got %0d exp 5", v); end
        wr(1'b1, 11, 1000, 1'b0); idle(2); wr(1'b1, 11, 536, 1'b1); idle(2); rd(1'b1, 11, v);
        checks++; if (v !== 16'sd6) begin errors++; $display("FAIL fwd_gap2 got %0d exp 6", v); end
        wr(1'b0, 10, 32'h7FFF_FF80, 1'b0); wr(1'b0, 10, 32'h0000_0100, 1'b1); idle(2); rd(1'b0, 10, v);
        checks++; if (v !== -16'sd32768) begin errors++; $display("FAIL acc_wrap got %0d exp -32768", v); end
    endtask

    task automatic test_conversion();
        int   words [7];
        out_t exps  [7];
        words = '{32'h7FFF_FFFF, 32'h8000_0000, -129, 127, 128, -384, -385};
        exps  = '{16'sd32767, -16'sd32768, -16'sd1, 16'sd0, 16'sd1, -16'sd1, -16'sd2};
        for (int i = 0; i < 7; i++) wr(1'b0, 12 + i, words[i], 1'b0);
        idle(2);
        for (int i = 0; i < 7; i++) begin
            rd(1'b0, 12 + i, v);
            checks++;
            if (v !== exps[i]) begin errors++; $display("FAIL conv_%0d got %0d exp %0d", i, v, exps[i]); end
        end
    endtask

    task automatic test_hold();
        wr(1'b1, 30, 768, 1'b0); idle(2); rd(1'b1, 30, v);
        checks++; if (v !== 16'sd3) begin errors++; $display("FAIL hold_first got %0d exp 3", v); end
        rd_bank = 1'b1; rd_addr = AW'(7);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_bank = 1'b0; wr_addr = AW'(30); wr_data = acc_t'(2560); wr_acc = 1'b0;
            tick();
            checks++;
            if (dst_data !== 16'sd3) begin errors++; $display("FAIL hold_cyc%0d got %0d exp 3", i, dst_data); end
        end
        wr_en = 1'b0;
        idle(2); rd(1'b0, 30, v);
        checks++; if (v !== 16'sd10) begin errors++; $display("FAIL hold_otherbank got %0d exp 10", v); end
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = AW'(20); wr_data = acc_t'(2560); wr_acc = 1'b0;
        rd_en = 1'b1; rd_bank = 1'b1; rd_addr = AW'(7);
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (dst_data !== 16'sd5) begin errors++; $display("FAIL simul_rd got %0d exp 5", dst_data); end
        idle(2); rd(1'b0, 20, v);
        checks++; if (v !== 16'sd10) begin errors++; $display("FAIL simul_wr got %0d exp 10", v); end
        wr(1'b0, 40, 256, 1'b0); idle(2);
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = AW'(40); wr_data = acc_t'(1280); wr_acc = 1'b0;
        tick();
        wr_en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(2); rd(1'b0, 40, v);
        checks++; if (v !== 16'sd1) begin errors++; $display("FAIL rst_drop got %0d exp 1", v); end
    endtask

    task automatic test_addr_range();
        wr(1'b0, 1452, 512, 1'b0); idle(2); rd(1'b0, 1452, v);
        checks++; if (v !== 16'sd2) begin errors++; $display("FAIL range_pre got %0d exp 2", v); end
        checks++; if (err_addr !== 1'b0) begin errors++; $display("FAIL err_clear got %0b exp 0", err_addr); end
        wr(1'b0, 3500, 2560, 1'b0);
        checks++; if (err_addr !== 1'b1) begin errors++; $display("FAIL err_wr got %0b exp 1", err_addr); end
        idle(3); rd(1'b0, 1452, v);
        checks++; if (v !== 16'sd2) begin errors++; $display("FAIL oor_wr_drop got %0d exp 2", v); end
        rd(1'b0, 3500, v);
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL oor_rd got %0d exp 0", v); end
        rst = 1'b1;
        tick();
        checks++; if (err_addr !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err_addr); end
        checks++; if (dst_data !== 16'sd0) begin errors++; $display("FAIL rst_dst got %0d exp 0", dst_data); end
        rst = 1'b0;
        rd(1'b0, 1452, v);
        checks++; if (v !== 16'sd2) begin errors++; $display("FAIL ram_kept got %0d exp 2", v); end
        rd(1'b1, 3100, v);
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL oor_rd2 got %0d exp 0", v); end
        checks++; if (err_addr !== 1'b1) begin errors++; $display("FAIL err_rd got %0b exp 1", err_addr); end
    endtask

`ifdef OUT_BUF_RELU_EN
    task automatic test_relu();
        wr(1'b0, 50, -1280, 1'b0); idle(2);
        relu_en = 1'b1; rd(1'b0, 50, v);
        checks++; if (v !== 16'sd0) begin errors++; $display("FAIL relu_neg got %0d exp 0", v); end
        rd(1'b0, 5, v);
        checks++; if (v !== 16'sd6) begin errors++; $display("FAIL relu_pos got %0d exp 6", v); end
        relu_en = 1'b0; rd(1'b0, 50, v);
        checks++; if (v !== -16'sd5) begin errors++; $display("FAIL relu_off got %0d exp -5", v); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_forwarding();
        test_conversion();
        test_hold();
        test_back_to_back();
`ifdef OUT_BUF_RELU_EN
        test_relu();
`endif
        test_addr_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
